pwm_duty_ramp: RTL
==================

// Module: pwm_duty_ramp
// PURPOSE
//   Soft-start duty-cycle sequencer feeding the Variable_PWM Dutycycle input.
//   Slews its duty output toward a requested target by STEP every DIV PWM
//   periods, updating only on PWM period boundaries so the PWM never sees a
//   mid-period duty change. Disabling ramps the duty down to 0, not a step.
// PARAMETERS
//   WIDTH  8  duty / target width in bits (matches PWM counter width)
//   STEP   4  duty increment/decrement per ramp step, 1..2^WIDTH-1
//   DIV    2  PWM periods per ramp step, >=1 (DIV=1: step every period)
// PORTS
//   clk          in   1      system clock; all state on rising edge
//   reset        in   1      asynchronous, active-high; clears all state
//   enable       in   1      1: ramp toward target_duty; 0: ramp toward 0
//   target_duty  in   WIDTH  requested duty; sampled only at period_end
//   period_end   in   1      1-cycle pulse, PWM counter wrap (last count)
//   duty         out  WIDTH  duty to PWM Dutycycle; changes only at period_end
//   at_target    out  1      1 when state==HOLD (duty equals latched target)
//   ramping_up   out  1      1 when state==UP
//   ramping_dn   out  1      1 when state==DOWN
// BEHAVIOUR
//   - One clock domain; reset asynchronous active-high (clk, reset).
//   - Reset: duty=0, tgt_q=0, div_cnt=0, state=HOLD -> at_target=1,
//     ramping_up=0, ramping_dn=0. Reset mid-ramp aborts at once, no resume.
//   - eff_tgt = enable ? target_duty : 0. Between period_end pulses all
//     registers hold; target_duty/enable changes are invisible until then.
//   - On clock edge with period_end=1, in order, using pre-edge values:
//       1. if state!=HOLD and div_cnt==DIV-1: step duty toward tgt_q,
//          div_cnt<=0; else if state!=HOLD: div_cnt<=div_cnt+1;
//          else (HOLD): div_cnt<=0.
//       2. tgt_q <= eff_tgt.
//       3. state <= UP if duty_next<eff_tgt, DOWN if duty_next>eff_tgt,
//          else HOLD (duty_next = value written in step 1).
//   - Step arithmetic in WIDTH+1 bits, clamped, never wraps:
//       UP:   duty_next = min(duty+STEP, tgt_q)
//       DOWN: duty_next = max(duty-STEP, tgt_q) (borrow => tgt_q)
//   - Latency: new target seen at boundary k -> first step at boundary k+DIV
//     (state leaves HOLD at k, div_cnt counts DIV-1..then steps).
//   - Target reversal mid-ramp: state re-evaluated next boundary, div_cnt
//     not reset; direction flips without overshoot past tgt_q.
//   - Target equal to duty: state HOLD, div_cnt cleared, duty constant.
//   - period_end held high multiple cycles: each high cycle is a boundary
//     (upstream must pulse); no internal edge detection.
//   - Outputs are registered; no combinational path input->output.
// TESTING
//   1. STEP=4, DIV=2, enable=1, target=0x10, period_end every 256 clk ->
//      duty 0x04,0x08,0x0C,0x10 after boundaries 3,5,7,9; at_target=1 from 9.
//   2. Same params, target=0x0E -> duty 0x04,0x08,0x0C,0x0E (clamped),
//      then HOLD; never 0x10.
//   3. Duty at 0xFE, enable->0 -> ramps_dn to 0x02 then 0x00, no wrap to
//      0xFC/0xFF; ramping_dn=1 throughout, at_target=1 at 0x00.
//   4. Change target_duty 0x10->0x80 mid-period (no period_end) -> duty,
//      state unchanged until next period_end pulse.
//   5. Assert reset asynchronously mid-ramp (duty=0x08, between edges) ->
//      duty=0, at_target=1 immediately; no steps until new target seen.
//   6. DIV=1, STEP=255, target=0xFF from 0 -> duty 0xFF after boundary 2
//      (single clamped step); then target 0x00 -> 0x00 after one step.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: soft-start duty-cycle sequencer for a PWM Dutycycle input.
// The duty output slews toward a requested target by STEP every DIV PWM
// periods. It only updates on PWM period boundaries, so the PWM never sees a
// duty change in the middle of a period. Clearing enable ramps the duty down
// to 0 instead of dropping it in one step.
//
// Ports:
//   i_clk          system clock, all state on the rising edge
//   i_reset        asynchronous active-high reset, clears all state
//   i_enable       1: ramp toward i_target_duty, 0: ramp toward 0
//   i_target_duty  requested duty, sampled only when i_period_end is high
//   i_period_end   one-cycle pulse on the PWM counter wrap
//   o_duty         duty for the PWM, changes only on a period boundary
//   o_at_target    state is HOLD (duty equals the latched target)
//   o_ramping_up   state is UP
//   o_ramping_dn   state is DOWN
module pwm_duty_ramp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 4,
  parameter int unsigned DIV   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_target_duty,
  input  logic             i_period_end,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_at_target,
  output logic             o_ramping_up,
  output logic             o_ramping_dn
);

  localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DN   = 2'd2;

  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_state;

  logic [WIDTH-1:0] w_eff_tgt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_dn_val;
  logic [WIDTH-1:0] w_duty_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_state_next;

  assign w_eff_tgt = i_enable ? i_target_duty : '0;

  // One extra bit so the step can never wrap; overshoot clamps to the target.
  assign w_sum    = {1'b0, r_duty} + STEP_EXT;
  assign w_diff   = {1'b0, r_duty} - STEP_EXT;
  assign w_up_val = (w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[WIDTH-1:0];
  // w_diff[WIDTH] is the borrow: stepping below zero lands on the target.
  assign w_dn_val = (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < r_tgt)) ? r_tgt
                                                                    : w_diff[WIDTH-1:0];

  always_comb begin
    w_duty_next = r_duty;
    w_cnt_next  = '0;
    if (r_state != ST_HOLD) begin
      if (r_cnt == DIV_LAST) begin
        w_duty_next = (r_state == ST_UP) ? w_up_val : w_dn_val;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
    // Direction is judged against the new target, so a reversal takes
    // effect at this boundary while the divider keeps its count.
    if (w_duty_next < w_eff_tgt) begin
      w_state_next = ST_UP;
    end else if (w_duty_next > w_eff_tgt) begin
      w_state_next = ST_DN;
    end else begin
      w_state_next = ST_HOLD;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_duty  <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_state <= ST_HOLD;
    end else if (i_period_end) begin
      r_duty  <= w_duty_next;
      r_tgt   <= w_eff_tgt;
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  assign o_duty       = r_duty;
  assign o_at_target  = (r_state == ST_HOLD);
  assign o_ramping_up = (r_state == ST_UP);
  assign o_ramping_dn = (r_state == ST_DN);

endmodule
